block_idx_fetch: RTL and testbench

Read-side sequencer for the block index bank. On a start command it streams a contiguous run of block-index words out of the bank by driving `ren_block_idx_bank`/`raddr_block_idx_bank`. It absorbs the bank's one-cycle read latency in a 2-entry output FIFO and presents each word to the PE-cluster dispatch logic over a valid/ready handshake. It never reads while an SPI write owns the bank port.

---
 rtl/block_idx_fetch.sv | 200 ++++++++++++++++++++
 tb/tb_block_idx_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_idx_fetch.sv
// ---------------------------------------------------------------------------
// block_idx_fetch
//
// Read-side sequencer for the block index bank. A start command loads a base
// address and a word count; the block then streams that contiguous run of
// block-index words out of the bank and hands them to the PE-cluster
// dispatch logic through a 2-entry first-word-fall-through FIFO. The FIFO
// absorbs the bank's one-cycle read latency.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start                    one-cycle command pulse (honoured only in IDLE)
//   base_addr, num_blocks    run description, sampled with start
//   spi_wen_block_bank_sync  SPI owns the bank port; no reads may issue
//   ren_block_idx_bank       bank read enable
//   raddr_block_idx_bank     bank read address
//   block_idx_data           bank read data (valid the cycle after ren)
//   blk_valid/blk_data/blk_last/blk_ready  output word stream
//   busy                     high while fetching or draining
//   done                     one-cycle completion pulse
//   dbg_state                current FSM state, for observation only
//
// Handshake: a word transfers in every cycle where blk_valid && blk_ready.
// While blk_valid is high and blk_ready is low, blk_data and blk_last hold.
// blk_valid never depends on blk_ready.
// ---------------------------------------------------------------------------
module block_idx_fetch #(
    parameter int  N_PE_CLUSTER     = 20,
    parameter int  DEPTH_BLOCK_BANK = 2048,
    localparam int AW               = $clog2(DEPTH_BLOCK_BANK)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AW-1:0]           base_addr,
    input  logic [AW:0]             num_blocks,
    input  logic                    spi_wen_block_bank_sync,
    output logic                    ren_block_idx_bank,
    output logic [AW-1:0]           raddr_block_idx_bank,
    input  logic [N_PE_CLUSTER-1:0] block_idx_data,
    output logic                    blk_valid,
    output logic [N_PE_CLUSTER-1:0] blk_data,
    output logic                    blk_last,
    input  logic                    blk_ready,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   REM_ONE  = (AW + 1)'(1);

    state_t                  state;
    state_t                  next_state;
    logic [AW-1:0]           addr;
    logic [AW:0]             remaining;
    logic                    inflight;
    logic                    inflight_last;
    logic                    run_empty;
    logic                    done_q;

    // FIFO entry = {last flag, word}
    logic [N_PE_CLUSTER:0]   fifo_mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fifo_count;
    logic [N_PE_CLUSTER:0]   head;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic [2:0]              occ;

    // ---------------------------------------------------------------------
    // Issue decision. Occupancy counts words already buffered plus the read
    // currently in flight, minus the word leaving this cycle; a new read is
    // only allowed when that leaves room for its data two cycles on.
    // ---------------------------------------------------------------------
    always_comb begin
        head  = fifo_mem[rd_ptr];
        pop   = (fifo_count != 2'd0) && blk_ready;
        push  = inflight;
        occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        issue = (state == S_FETCH) && (remaining != '0) &&
                !spi_wen_block_bank_sync && (occ < 3'd2);
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (num_blocks == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue && (remaining == REM_ONE)) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The flagged word is the final one, so once it leaves
                // the FIFO is empty and nothing remains in flight.
                if (pop && head[N_PE_CLUSTER]) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, run counters and read pipeline
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            run_empty     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= issue;
            if (issue) begin
                inflight_last <= (remaining == REM_ONE);
            end

            if ((state == S_IDLE) && start) begin
                addr      <= base_addr;
                remaining <= num_blocks;
                run_empty <= (num_blocks == '0);
            end else if (issue) begin
                addr      <= addr + ADDR_ONE;   // power-of-two depth: natural wrap
                remaining <= remaining - REM_ONE;
            end

            // A real run signals completion the cycle after its last word
            // leaves; an empty run signals it on the way out of DONE.
            done_q <= ((state == S_DRAIN) && pop && head[N_PE_CLUSTER]) ||
                      ((state == S_DONE) && run_empty);
        end
    end

    // ---------------------------------------------------------------------
    // 2-entry FWFT FIFO. Capture only when a read was issued last cycle;
    // otherwise the bank output is stale.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {inflight_last, block_idx_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        ren_block_idx_bank   = issue;
        raddr_block_idx_bank = addr;
        blk_valid            = (fifo_count != 2'd0);
        blk_data             = head[N_PE_CLUSTER-1:0];
        blk_last             = blk_valid && head[N_PE_CLUSTER];
        busy                 = (state == S_FETCH) || (state == S_DRAIN);
        done                 = done_q;
        dbg_state            = state;
    end

endmodule

// File: tb/tb_block_idx_fetch.sv
module tb_block_idx_fetch;

    localparam int N     = 20;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    typedef struct {
        int base;
        int n;
        int ready_mode;    // 0: always ready, 1: pattern 1,0,0,1
        int spi_s;         // first relative cycle of SPI write (-1 none)
        int spi_len;
        int restart_rel;   // relative cycle of an extra start pulse (-1 none)
        int exp_done_rel;  // -1: must follow last pop by one cycle
    } vec_t;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [AW:0]    num_blocks = '0;
    logic           spi = 1'b0;
    logic           ren;
    logic [AW-1:0]  raddr;
    logic [N-1:0]   block_idx_data = '0;
    logic           blk_valid;
    logic [N-1:0]   blk_data;
    logic           blk_last;
    logic           blk_ready = 1'b0;
    logic           busy;
    logic           done;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    block_idx_fetch #(.N_PE_CLUSTER(N), .DEPTH_BLOCK_BANK(DEPTH)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start                   (start),
        .base_addr               (base_addr),
        .num_blocks              (num_blocks),
        .spi_wen_block_bank_sync (spi),
        .ren_block_idx_bank      (ren),
        .raddr_block_idx_bank    (raddr),
        .block_idx_data          (block_idx_data),
        .blk_valid               (blk_valid),
        .blk_data                (blk_data),
        .blk_last                (blk_last),
        .blk_ready               (blk_ready),
        .busy                    (busy),
        .done                    (done),
        .dbg_state               (dbg_state)
    );

    // bank model: one-cycle read latency, output holds when not reading
    logic [N-1:0] bank [DEPTH];
    always @(posedge clk) if (ren) block_idx_data <= bank[raddr];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [N:0]    exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    bit   mon_en = 1'b0;
    int   c0 = 0;
    int   fifo_tb = 0;
    int   inflight_tb = 0;
    bit   prev_hold = 1'b0;
    logic [N:0] prev_word = '0;
    int   last_pop_rel = -1;
    int   done_rel = -1;
    int   done_cnt = 0;
    int   ren_cnt = 0;
    bit   busy_seen = 1'b0;
    logic tr_ren [16];
    logic [AW-1:0] tr_raddr [16];
    logic tr_valid [16];
    logic tr_last [16];
    logic tr_busy [16];
    logic tr_done [16];

    always @(negedge clk) begin
        int   rel;
        logic pop;
        rel = cyc - c0;
        pop = blk_valid && blk_ready;
        if (mon_en) begin
            chk("valid_vs_occupancy", 32'(blk_valid), 32'(fifo_tb != 0));
            if (prev_hold) begin
                chk("stall_valid", 32'(blk_valid), 32'd1);
                chk("stall_word", 32'({blk_last, blk_data}), 32'(prev_word));
            end
            if (ren) begin
                ren_cnt++;
                chk("ren_during_spi", 32'(spi), 32'd0);
                chk("occupancy_le_2", 32'((fifo_tb + inflight_tb - int'(pop)) < 2), 32'd1);
                if (exp_addr_q.size() == 0) chk("extra_read", 32'd1, 32'd0);
                else chk("raddr", 32'(raddr), 32'(exp_addr_q.pop_front()));
            end
            if (pop) begin
                last_pop_rel = rel;
                if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
                else chk("word", 32'({blk_last, blk_data}), 32'(exp_q.pop_front()));
            end
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            if (rel >= 0 && rel < 16) begin
                tr_ren[rel]   = ren;
                tr_raddr[rel] = raddr;
                tr_valid[rel] = blk_valid;
                tr_last[rel]  = blk_last;
                tr_busy[rel]  = busy;
                tr_done[rel]  = done;
            end
        end
        if (!rst_n) begin
            fifo_tb     = 0;
            inflight_tb = 0;
            prev_hold   = 1'b0;
        end else begin
            fifo_tb     = fifo_tb + inflight_tb - int'(pop);
            inflight_tb = int'(ren);
            prev_hold   = blk_valid && !blk_ready;
            prev_word   = {blk_last, blk_data};
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic rdy(input int mode, input int r);
        if (mode == 0) return 1'b1;
        return ((r % 4) == 0) || ((r % 4) == 3);
    endfunction

    task automatic load_expect(input int base, input int n);
        logic [AW-1:0] a;
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < n; i++) begin
            a = AW'(base) + AW'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back({(i == n - 1), bank[a]});
        end
    endtask

    task automatic clear_run_stats();
        last_pop_rel = -1;
        done_rel     = -1;
        done_cnt     = 0;
        ren_cnt      = 0;
        busy_seen    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tr_ren[i] = 1'b0; tr_raddr[i] = '0; tr_valid[i] = 1'b0;
            tr_last[i] = 1'b0; tr_busy[i] = 1'b0; tr_done[i] = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  limit;
        bit  finished;
        load_expect(v.base, v.n);
        limit    = v.n * 4 + 60;
        finished = 1'b0;
        @(posedge clk); #1;
        clear_run_stats();
        c0         = cyc;
        start      = 1'b1;
        base_addr  = AW'(v.base);
        num_blocks = (AW + 1)'(v.n);
        blk_ready  = rdy(v.ready_mode, 0);
        spi        = (v.spi_s == 0);
        for (int r = 1; r < limit && !finished; r++) begin
            @(posedge clk); #1;
            start = (r == v.restart_rel);
            if (start) begin
                base_addr  = 11'h555;
                num_blocks = 12'd3;
            end
            blk_ready = rdy(v.ready_mode, r);
            spi = (v.spi_s >= 0) && (r >= v.spi_s) && (r < v.spi_s + v.spi_len);
            if (done_cnt > 0 && r > done_rel + 3) finished = 1'b1;
        end
        start = 1'b0;
        spi   = 1'b0;
        if (done_cnt == 0) chk($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
        chk($sformatf("v%0d_done_count", idx), 32'(done_cnt), 32'd1);
        if (v.exp_done_rel >= 0)
            chk($sformatf("v%0d_done_rel", idx), 32'(done_rel), 32'(v.exp_done_rel));
        else
            chk($sformatf("v%0d_done_after_last_pop", idx), 32'(done_rel), 32'(last_pop_rel + 1));
        chk($sformatf("v%0d_words_missing", idx), 32'(exp_q.size()), 32'd0);
        chk($sformatf("v%0d_reads_missing", idx), 32'(exp_addr_q.size()), 32'd0);
        chk($sformatf("v%0d_ren_count", idx), 32'(ren_cnt), 32'(v.n));
        if (v.n == 0) chk($sformatf("v%0d_busy_on_empty", idx), 32'(busy_seen), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ren"}, 32'(ren), 32'd0);
        chk({tag, "_raddr"}, 32'(raddr), 32'd0);
        chk({tag, "_valid"}, 32'(blk_valid), 32'd0);
        chk({tag, "_data"}, 32'(blk_data), 32'd0);
        chk({tag, "_last"}, 32'(blk_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- main test ----------------
    vec_t vecs [8];

    initial begin
        for (int i = 0; i < DEPTH; i++) bank[i] = N'((i * 32'h9E37) ^ 32'hA5A5 ^ (i << 9));

        //          base    n     rdy spi_s len restart done
        vecs[0] = '{12'h010, 4,    0,  -1,   0,  -1,     7};
        vecs[1] = '{2046,    4,    0,  -1,   0,  -1,     7};
        vecs[2] = '{12'h040, 8,    1,  -1,   0,  -1,    -1};
        vecs[3] = '{12'h080, 8,    0,   3,   3,  -1,    14};
        vecs[4] = '{12'h000, 0,    0,  -1,   0,  -1,     2};
        vecs[5] = '{12'h100, 8,    0,  -1,   0,   3,    11};
        vecs[6] = '{12'h000, 2048, 0,  -1,   0,  -1,  2051};
        vecs[7] = '{12'h7F0, 20,   1,   5,   2,  -1,    -1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k], k);
            if (k == 0) begin
                // exact cycle trace of the basic run
                for (int r = 0; r < 10; r++) begin
                    chk($sformatf("trace_ren_c%0d", r), 32'(tr_ren[r]), 32'(r >= 1 && r <= 4));
                    if (r >= 1 && r <= 4)
                        chk($sformatf("trace_raddr_c%0d", r), 32'(tr_raddr[r]), 32'(12'h010 + r - 1));
                    chk($sformatf("trace_valid_c%0d", r), 32'(tr_valid[r]), 32'(r >= 3 && r <= 6));
                    chk($sformatf("trace_last_c%0d", r), 32'(tr_last[r]), 32'(r == 6));
                    chk($sformatf("trace_busy_c%0d", r), 32'(tr_busy[r]), 32'(r >= 1 && r <= 6));
                    chk($sformatf("trace_done_c%0d", r), 32'(tr_done[r]), 32'(r == 7));
                end
            end
            repeat (2) @(posedge clk);
        end

        // reset in the middle of a run
        load_expect(12'h200, 10);
        @(posedge clk); #1;
        clear_run_stats();
        c0 = cyc;
        start = 1'b1; base_addr = 11'h200; num_blocks = 12'd10; blk_ready = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (r == 5) rst_n = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (6) @(posedge clk);
        chk("midrun_reset_no_done", 32'(done_cnt), 32'd0);

        // clean run after the abort
        run_vec(vecs[0], 8);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
